// File: rtl/uart_value_reporter_if.sv
// Transmit-side link between the value reporter and the UART string handler.
// Handshake: tx_req is a single-cycle request raised only while tx_busy is low;
// tx_string/tx_length are held stable until the next report is accepted, and
// tx_done is a single-cycle pulse from the handler once the whole string has left.
interface uart_value_reporter_if;
   logic [1023:0] tx_string;
   logic [7:0]    tx_length;
   logic          tx_req;
   logic          tx_busy;
   logic          tx_done;

   modport master (
      output tx_string,
      output tx_length,
      output tx_req,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  tx_string,
      input  tx_length,
      input  tx_req,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/uart_value_reporter.sv
// Turns a binary value into "<TAG>=<decimal>\r\n" via sequential double-dabble,
// packs it byte by byte without leading zeros and hands it to the UART string path.
module uart_value_reporter #(
   parameter int         VALUE_WIDTH = 32,
   parameter int         DIGITS      = 10,
   parameter bit         SIGNED      = 1'b0,
   parameter logic [7:0] TAG_CHAR    = 8'h46
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic [VALUE_WIDTH-1:0]  value_in,
   input  logic                    value_valid,
   output logic                    value_ready,
   output logic                    dropped,
   output logic                    report_done,
   output logic [2:0]              fsm_state,
   uart_value_reporter_if.master   tx
);

   localparam int BW    = 4 * DIGITS;
   localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CONV = 3'd1,
      S_PACK = 3'd2,
      S_REQ  = 3'd3,
      S_WAIT = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [VALUE_WIDTH-1:0] mag;
   logic [BW-1:0]          bcd;
   logic [BW-1:0]          bcd_adj;
   logic                   neg;
   logic [CNT_W-1:0]       conv_cnt;
   logic [DIG_W-1:0]       dig_idx;
   logic                   started;
   logic [7:0]             wptr;
   logic [1023:0]          tx_string_q;
   logic [7:0]             tx_length_q;
   logic                   tx_req_c;

   logic                   accept;
   logic                   in_neg;
   logic                   pack_first;
   logic                   pack_last;
   logic [3:0]             digit;
   logic                   write_digit;
   logic [7:0]             base_ptr;
   logic [7:0]             ptr_after;
   logic [10:0]            pos_digit;
   logic [10:0]            pos_cr;
   logic [10:0]            pos_lf;

   function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign value_ready  = (state == S_IDLE);
   assign accept       = value_valid && value_ready;
   assign in_neg       = SIGNED && value_in[VALUE_WIDTH-1];
   assign bcd_adj      = add3(bcd);
   assign fsm_state    = state;

   assign tx.tx_string = tx_string_q;
   assign tx.tx_length = tx_length_q;
   assign tx.tx_req    = tx_req_c;

   // Digits are scanned MSB-first by shifting the BCD register up each PACK cycle.
   assign pack_first  = (dig_idx == DIG_W'(DIGITS - 1));
   assign pack_last   = (dig_idx == '0);
   assign digit       = bcd[BW-1 -: 4];
   assign write_digit = (digit != 4'd0) || started || pack_last;
   assign base_ptr    = pack_first ? (neg ? 8'd3 : 8'd2) : wptr;
   assign ptr_after   = base_ptr + {7'd0, write_digit};
   assign pos_digit   = {base_ptr, 3'b000};
   assign pos_cr      = {ptr_after, 3'b000};
   assign pos_lf      = {ptr_after + 8'd1, 3'b000};

   always_comb begin
      state_next = state;
      tx_req_c   = 1'b0;
      case (state)
         S_IDLE: if (value_valid) state_next = S_CONV;
         S_CONV: if (conv_cnt == CNT_W'(VALUE_WIDTH - 1)) state_next = S_PACK;
         S_PACK: if (pack_last) state_next = S_REQ;
         S_REQ: begin
            if (!tx.tx_busy) begin
               tx_req_c   = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: if (tx.tx_done) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= S_IDLE;
      else            state <= state_next;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mag      <= '0;
         bcd      <= '0;
         neg      <= 1'b0;
         conv_cnt <= '0;
         dig_idx  <= '0;
         started  <= 1'b0;
         wptr     <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mag      <= in_neg ? (~value_in + 1'b1) : value_in;
                  neg      <= in_neg;
                  bcd      <= '0;
                  conv_cnt <= '0;
                  dig_idx  <= DIG_W'(DIGITS - 1);
                  started  <= 1'b0;
               end
            end
            S_CONV: begin
               {bcd, mag} <= {bcd_adj[BW-2:0], mag, 1'b0};
               conv_cnt   <= conv_cnt + 1'b1;
            end
            S_PACK: begin
               bcd     <= bcd << 4;
               dig_idx <= dig_idx - 1'b1;
               started <= started || write_digit;
               wptr    <= ptr_after;
            end
            default: ;
         endcase
      end
   end

   // The string is rebuilt from scratch on the first PACK cycle, then only appended to.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_string_q <= '0;
         tx_length_q <= 8'd0;
      end else if (state == S_PACK) begin
         if (pack_first) begin
            tx_string_q        <= '0;
            tx_string_q[7:0]   <= TAG_CHAR;
            tx_string_q[15:8]  <= 8'h3D;
            if (neg) tx_string_q[23:16] <= 8'h2D;
         end
         if (write_digit) tx_string_q[pos_digit +: 8] <= {4'h3, digit};
         if (pack_last) begin
            tx_string_q[pos_cr +: 8] <= 8'h0D;
            tx_string_q[pos_lf +: 8] <= 8'h0A;
            tx_length_q              <= ptr_after + 8'd2;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dropped     <= 1'b0;
         report_done <= 1'b0;
      end else begin
         dropped     <= value_valid && !value_ready;
         report_done <= (state == S_WAIT) && tx.tx_done;
      end
   end

endmodule

// File: doc/uart_value_reporter.md
# uart_value_reporter

Formats a binary measurement value into an ASCII report line `<TAG>=<decimal>\r\n` and hands it to the UART string transmit path (`uart_string_handle` tx side) through its string/length/req/busy/done handshake. It sits directly upstream of the string handler's transmit port, so measurement logic can report a number without building strings. Conversion uses a sequential double-dabble binary-to-BCD engine, followed by a byte-per-cycle packer that suppresses leading zeros.

## Interface
- `VALUE_WIDTH`, default 32: width of `value_in`.
- `DIGITS`, default 10: BCD digits. Must satisfy 10^DIGITS > 2^VALUE_WIDTH.
- `SIGNED`, default 0: 1 = `value_in` is two's complement; negative values are printed with `-`.
- `TAG_CHAR`, default 8'h46 ("F"): first byte of every report.
- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `value_in` in VALUE_WIDTH: value to report; sampled on acceptance.
- `value_valid` in 1: request to report `value_in`.
- `value_ready` out 1: high only in IDLE. Acceptance is `value_valid && value_ready`.
- `dropped` out 1: 1-cycle pulse when `value_valid` is high while `value_ready` is low.
- `tx_string` out 1024: byte k at [8k+7:8k]. Byte 0 is sent first. Unused bytes are 0.
- `tx_length` out 8: number of valid bytes in `tx_string`.
- `tx_req` out 1: 1-cycle request pulse to the string handler.
- `tx_busy` in 1: string handler is transmitting.
- `tx_done` in 1: 1-cycle pulse from the string handler when the string has been fully sent.
- `report_done` out 1: 1-cycle pulse when the report has been fully sent.

## Operation
- States: IDLE -> CONV -> PACK -> REQ -> WAIT -> IDLE.
- **IDLE**
  - `value_ready`=1.
  - On acceptance: latch the magnitude. If SIGNED and the MSB is set, the magnitude is the two's-complement negation and the neg flag is set.
  - Clear the BCD register, go to CONV.
- **CONV**
  - Runs exactly VALUE_WIDTH cycles.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, magnitude} left by 1.
- **PACK**
  - Runs exactly DIGITS cycles, scanning digits from most significant.
  - First cycle: clear `tx_string`; write byte0=TAG_CHAR and byte1="=" ; if neg, write byte2="-". Write pointer = 2 or 3.
  - Each cycle: a digit is written as 8'h30+d if it is nonzero, or if an earlier digit was written, or if it is the last digit.
  - On the last PACK cycle, also append 8'h0D and 8'h0A. Set `tx_length` = final pointer.
- **REQ**
  - Pulse `tx_req` in the first REQ cycle in which `tx_busy`=0, then go to WAIT.
  - While `tx_busy`=1, hold in REQ with no pulse.
- **WAIT**
  - On `tx_done`=1, pulse `report_done` the next cycle and return to IDLE.
  - No timeout.
  - A `tx_done` seen outside WAIT is ignored.
- **Output stability:** `tx_string` and `tx_length` are stable from the cycle after the last PACK cycle until the next acceptance.
- **Width:** the maximum string is 2+1+DIGITS+2 = 15 bytes at the defaults, so it always fits in 1024 bits.
- **Reset** (any state, including mid-conversion or WAIT):
  - `value_ready`=1.
  - `tx_string`=0, `tx_length`=0.
  - `tx_req`=0, `report_done`=0, `dropped`=0.
  - State = IDLE.

## Timing
- Acceptance edge = cycle 0.
- CONV occupies cycles 1..VALUE_WIDTH. PACK occupies the next DIGITS cycles.
- Earliest `tx_req` is cycle VALUE_WIDTH+DIGITS+1 (cycle 43 at the defaults).
- `report_done` fires 1 cycle after `tx_done`. `value_ready` is high in the cycle after `report_done`'s cycle.
- `dropped` goes high 1 cycle after the offending `value_valid` edge.
- Throughput: one report per (43 + UART time) cycles. Extra requests are dropped, never queued.

## Test plan
- **Unsigned 12345:** accept 12345 (SIGNED=0) -> bytes "F=12345\r\n", `tx_length`=9, `tx_req` pulse at cycle 43, `tx_string` bytes 9+ all 0.
- **Zero:** accept 0 -> "F=0\r\n", `tx_length`=5.
- **Extremes:**
  - 32'hFFFFFFFF, SIGNED=0 -> "F=4294967295\r\n", length 14.
  - 32'hFFFFFFFF, SIGNED=1 -> "F=-1\r\n", length 6.
  - 32'h80000000, SIGNED=1 -> "F=-2147483648\r\n", length 15.
- **Busy hold-off:** `tx_busy` held 1 from cycle 40 to 140 -> no `tx_req` until cycle 141, exactly one pulse, `tx_string` unchanged throughout.
- **Handshake and drop:** `value_valid` at cycle 10 -> `dropped` pulse at cycle 11, report unaffected. `tx_done` injected at cycle 60 -> `report_done` at cycle 61, `value_ready`=1 at cycle 62.
- **Reset mid-operation:** assert `sys_rst_n`=0 at cycle 20 (mid-CONV) -> all outputs return to their reset values immediately and no `tx_req` follows. A new value accepted after release produces a correct string.
